// File: rtl/csr_axi_master.sv
// csr_axi_master: single-outstanding AXI4 master that turns simple register
// read/write requests into single-beat AXI4 transactions. One request in
// flight at a time; each accepted request yields exactly one response.
module csr_axi_master #(
  parameter int ADDR_W = 5,
  parameter int ID_W   = 5,
  parameter int AXI_ID = 0
) (
  input  logic              s_aclk,
  input  logic              s_areset,
  // request side
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  // response side
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  // AW channel
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [ID_W-1:0]   m_axi_awid,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  // W channel
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  // B channel
  input  logic [ID_W-1:0]   m_axi_bid,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  // AR channel
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  // R channel
  input  logic [31:0]       m_axi_rdata,
  input  logic [ID_W-1:0]   m_axi_rid,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WB   = 3'd2,
    S_RA   = 3'd3,
    S_RD   = 3'd4,
    S_RSP  = 3'd5
  } state_e;

  localparam logic [ID_W-1:0] ID_C      = ID_W'(AXI_ID);
  localparam logic [1:0]      RESP_SLV  = 2'b10;

  state_e              state_q, state_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic                r_err;

  // Next-state and held-register logic; every output toward AXI or the
  // response side comes from a flop, so no input reaches an output directly.
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    r_err       = (m_axi_rid != ID_C) || !m_axi_rlast;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RA;
          end
        end
      end
      S_WR: begin
        // AW and W retire independently; leave once both are gone
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    state_d   = S_WB;
      end
      S_WB: begin
        if (m_axi_bvalid) begin
          rsp_rdata_d = 32'd0;
          rsp_resp_d  = (m_axi_bid != ID_C) ? RESP_SLV : m_axi_bresp;
          state_d     = S_RSP;
        end
      end
      S_RA: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_RD;
        end
      end
      S_RD: begin
        if (m_axi_rvalid) begin
          rsp_rdata_d = r_err ? 32'd0 : m_axi_rdata;
          rsp_resp_d  = r_err ? RESP_SLV : m_axi_rresp;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and held registers; reset abandons any in-flight transaction.
  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      state_q     <= S_IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE) && !s_areset;
  assign rsp_valid     = (state_q == S_RSP);
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awid    = ID_C;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = awvalid_q;

  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_wvalid  = wvalid_q;

  assign m_axi_bready  = (state_q == S_WB);

  assign m_axi_araddr  = addr_q;
  assign m_axi_arid    = ID_C;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid_q;

  assign m_axi_rready  = (state_q == S_RD);

endmodule
